// File: rtl/sqrt_batch_seq.sv
// sqrt_batch_seq: batch sequencer between the ioports command interpreter and
// the psdsqrt core. The host queues arguments into an argument FIFO, the block
// feeds them one at a time to the sqrt core, and the roots are collected in a
// result FIFO that the host pops (show-ahead read).
//
// Ports:
//   clock, reset       master clock, synchronous active-high reset
//   push, xin_wr       1-cycle strobe + argument to enqueue
//   pop                1-cycle strobe: drop head of result FIFO
//   res_rd             head of result FIFO (0 when empty)
//   arg_count          argument FIFO occupancy (0..DEPTH)
//   res_count          result FIFO occupancy (0..DEPTH)
//   overflow           sticky: a push was dropped
//   sq_run, sq_xin     run pulse and argument to sqrt core
//   sq_busy, sq_sqrt   sqrt core busy flag and result
//   done_count         (SQRT_BATCH_STATS_EN only) number of stored results
//
// Optional feature macro: SQRT_BATCH_STATS_EN adds the done_count output.
module sqrt_batch_seq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XW    = 32,
  parameter int unsigned RW    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [XW-1:0]            xin_wr,
  input  logic                     pop,
  output logic [RW-1:0]            res_rd,
  output logic [$clog2(DEPTH):0]   arg_count,
  output logic [$clog2(DEPTH):0]   res_count,
  output logic                     overflow,
  output logic                     sq_run,
  output logic [XW-1:0]            sq_xin,
  input  logic                     sq_busy,
  input  logic [RW-1:0]            sq_sqrt
`ifdef SQRT_BATCH_STATS_EN
  ,
  output logic [15:0]              done_count
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_STORE} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     arg_mem_q [DEPTH];
  logic [XW-1:0]     arg_mem_d [DEPTH];
  logic [RW-1:0]     res_mem_q [DEPTH];
  logic [RW-1:0]     res_mem_d [DEPTH];
  logic [AW-1:0]     arg_wr_ptr_q, arg_wr_ptr_d, arg_rd_ptr_q, arg_rd_ptr_d;
  logic [AW-1:0]     res_wr_ptr_q, res_wr_ptr_d, res_rd_ptr_q, res_rd_ptr_d;
  logic [CNT_W-1:0]  arg_count_q, arg_count_d, res_count_q, res_count_d;
  logic              overflow_q, overflow_d;
  logic [XW-1:0]     sq_xin_q, sq_xin_d;
`ifdef SQRT_BATCH_STATS_EN
  logic [15:0]       done_count_q, done_count_d;
`endif

  logic arg_pop, arg_push_ok, res_store, res_pop_ok;

  always_comb begin
    arg_pop     = (state_q == S_START);
    arg_push_ok = push && ((arg_count_q != FULL) || arg_pop);
    res_store   = (state_q == S_STORE);
    res_pop_ok  = pop && (res_count_q != '0);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if ((arg_count_q != '0) && (res_count_q != FULL)) state_d = S_START;
      S_START: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT:  if (!sq_busy) state_d = S_STORE;
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: FIFOs, counts, core argument register
  always_comb begin
    arg_mem_d    = arg_mem_q;
    res_mem_d    = res_mem_q;
    arg_wr_ptr_d = arg_wr_ptr_q;
    arg_rd_ptr_d = arg_rd_ptr_q;
    res_wr_ptr_d = res_wr_ptr_q;
    res_rd_ptr_d = res_rd_ptr_q;
    arg_count_d  = arg_count_q;
    res_count_d  = res_count_q;
    overflow_d   = overflow_q | (push && !arg_push_ok);
    sq_xin_d     = sq_xin_q;

    if (arg_push_ok) begin
      arg_mem_d[arg_wr_ptr_q] = xin_wr;
      arg_wr_ptr_d = arg_wr_ptr_q + AW'(1);
    end
    if (arg_pop) arg_rd_ptr_d = arg_rd_ptr_q + AW'(1);
    case ({arg_push_ok, arg_pop})
      2'b10:   arg_count_d = arg_count_q + CNT_W'(1);
      2'b01:   arg_count_d = arg_count_q - CNT_W'(1);
      default: arg_count_d = arg_count_q;
    endcase

    if (res_store) begin
      res_mem_d[res_wr_ptr_q] = sq_sqrt;
      res_wr_ptr_d = res_wr_ptr_q + AW'(1);
    end
    if (res_pop_ok) res_rd_ptr_d = res_rd_ptr_q + AW'(1);
    case ({res_store, res_pop_ok})
      2'b10:   res_count_d = res_count_q + CNT_W'(1);
      2'b01:   res_count_d = res_count_q - CNT_W'(1);
      default: res_count_d = res_count_q;
    endcase

    // Latch the head on entry to START so sq_xin is already valid in the
    // cycle the core samples sq_run; it then holds until the next START.
    if ((state_q == S_IDLE) && (state_d == S_START)) sq_xin_d = arg_mem_q[arg_rd_ptr_q];
  end

`ifdef SQRT_BATCH_STATS_EN
  always_comb begin
    done_count_d = done_count_q;
    if (res_store) done_count_d = done_count_q + 16'd1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      arg_mem_q    <= '{default: '0};
      res_mem_q    <= '{default: '0};
      arg_wr_ptr_q <= '0;
      arg_rd_ptr_q <= '0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      arg_count_q  <= '0;
      res_count_q  <= '0;
      overflow_q   <= 1'b0;
      sq_xin_q     <= '0;
`ifdef SQRT_BATCH_STATS_EN
      done_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      arg_mem_q    <= arg_mem_d;
      res_mem_q    <= res_mem_d;
      arg_wr_ptr_q <= arg_wr_ptr_d;
      arg_rd_ptr_q <= arg_rd_ptr_d;
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      arg_count_q  <= arg_count_d;
      res_count_q  <= res_count_d;
      overflow_q   <= overflow_d;
      sq_xin_q     <= sq_xin_d;
`ifdef SQRT_BATCH_STATS_EN
      done_count_q <= done_count_d;
`endif
    end
  end

  always_comb begin
    res_rd    = (res_count_q != '0) ? res_mem_q[res_rd_ptr_q] : '0;
    arg_count = arg_count_q;
    res_count = res_count_q;
    overflow  = overflow_q;
    sq_run    = (state_q == S_START);
    sq_xin    = sq_xin_q;
`ifdef SQRT_BATCH_STATS_EN
    done_count = done_count_q;
`endif
  end

endmodule
